// File: rtl/fp_mul_norm_round_pkg.sv
// Shared binary32 constants, rounding modes and flag indices.
// Used by the FP multiplier back end and reusable FP helpers.
package fp_mul_norm_round_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    SPECIAL_NORM = 2'b00,
    SPECIAL_ZERO = 2'b01,
    SPECIAL_INF  = 2'b10,
    SPECIAL_NAN  = 2'b11
  } special_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] F32_QNAN   = 32'h7FC0_0000;
  localparam logic [31:0] F32_MAXFIN = 32'h7F7F_FFFF;
  localparam logic [31:0] F32_INF    = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    rm_e         rm;
    special_e    special;
    logic        nv;
    logic [22:0] m;
    logic        g;
    logic        s;
  } s1_t;

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(
    input logic [2:0] rm
  );
    rm_e r;
    r = RM_RNE;
    if (rm <= 3'd4) r = rm_e'(rm);
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_norm_round_round_inc.sv
// Rounding increment decision from sign, mode, lsb, guard and sticky.
// Shared between the FP multiplier and adder back ends.
module fp_round_inc
  import fp_mul_norm_round_pkg::*;
(
  input  logic       i_sign,
  input  logic [2:0] i_rm,
  input  logic       i_lsb,
  input  logic       i_g,
  input  logic       i_s,
  output logic       o_inc
);

  logic w_inexact;

  assign w_inexact = i_g | i_s;

  always_comb begin
    o_inc = i_g & (i_s | i_lsb);
    case (i_rm)
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & w_inexact;
      RM_RUP:  o_inc = ~i_sign & w_inexact;
      RM_RMM:  o_inc = i_g;
      default: o_inc = i_g & (i_s | i_lsb);
    endcase
  end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Post-multiply normalize (S1) and round/pack (S2) for binary32.
// Two-stage valid/ready pipeline with flush and fflags output.
module fp_mul_norm_round
  import fp_mul_norm_round_pkg::*;
#(
  parameter int EXP_W   = 10,
  parameter int FLAGS_W = 5
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_flush,
  input  logic                    in_valid,
  output logic                    out_ready_up,
  input  logic [47:0]             in_product,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp_sum,
  input  logic [1:0]              in_special,
  input  logic                    in_invalid,
  input  logic [2:0]              in_rm,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic [31:0]             out_result,
  output logic [FLAGS_W-1:0]      out_fflags
);

  logic                  r_s1_v;
  s1_t                   r_s1;
  logic signed [EXP_W:0] r_s1_e;
  logic                  r_s2_v;
  logic [31:0]           r_result;
  logic [FLAGS_W-1:0]    r_fflags;

  logic                  w_s2_can_take;
  logic                  w_ready_up;
  logic                  w_s1_load;
  logic                  w_s2_load;
  s1_t                   w_s1_next;
  logic signed [EXP_W:0] w_s1_e_next;

  logic                  w_inc;
  logic [23:0]           w_sum;
  logic                  w_carry;
  logic [22:0]           w_frac;
  logic signed [EXP_W:0] w_e_rnd;
  int                    w_e_int;
  logic [31:0]           w_result;
  logic [FLAGS_W-1:0]    w_flags;

  assign w_s2_can_take = ~r_s2_v | in_ready;
  assign w_ready_up    = ~r_s1_v | w_s2_can_take;
  assign w_s1_load     = in_valid & w_ready_up & ~in_flush;
  assign w_s2_load     = r_s1_v & w_s2_can_take & ~in_flush;

  assign out_ready_up = w_ready_up;
  assign out_valid    = r_s2_v;
  assign out_result   = r_result;
  assign out_fflags   = r_fflags;

  // S1: align the product so the hidden bit is dropped.
  always_comb begin
    w_s1_next         = '0;
    w_s1_next.sign    = in_sign;
    w_s1_next.rm      = rm_decode(in_rm);
    w_s1_next.nv      = in_invalid;
    w_s1_next.special = special_e'(in_special);
    if (in_special == SPECIAL_NORM && in_product == 48'd0)
      w_s1_next.special = SPECIAL_ZERO;
    if (in_product[47]) begin
      w_s1_next.m = in_product[46:24];
      w_s1_next.g = in_product[23];
      w_s1_next.s = |in_product[22:0];
    end else begin
      w_s1_next.m = in_product[45:23];
      w_s1_next.g = in_product[22];
      w_s1_next.s = |in_product[21:0];
    end
  end

  assign w_s1_e_next = {in_exp_sum[EXP_W-1], in_exp_sum}
                     + {{EXP_W{1'b0}}, in_product[47]};

  // S2: round, then classify the rounded exponent.
  fp_round_inc u_round_inc (
    .i_sign (r_s1.sign),
    .i_rm   (r_s1.rm),
    .i_lsb  (r_s1.m[0]),
    .i_g    (r_s1.g),
    .i_s    (r_s1.s),
    .o_inc  (w_inc)
  );

  assign w_sum   = {1'b0, r_s1.m} + {23'd0, w_inc};
  assign w_carry = w_sum[23];
  assign w_frac  = w_sum[22:0];
  assign w_e_rnd = r_s1_e + {{EXP_W{1'b0}}, w_carry};
  assign w_e_int = int'(w_e_rnd);

  always_comb begin
    w_result          = {r_s1.sign, w_e_rnd[7:0], w_frac};
    w_flags           = '0;
    w_flags[FLAG_NV]  = r_s1.nv;
    w_flags[FLAG_NX]  = r_s1.g | r_s1.s;
    if (r_s1.special != SPECIAL_NORM) begin
      w_flags          = '0;
      w_flags[FLAG_NV] = r_s1.nv;
      case (r_s1.special)
        SPECIAL_ZERO: w_result = {r_s1.sign, 31'd0};
        SPECIAL_INF:  w_result = {r_s1.sign, F32_INF[30:0]};
        default:      w_result = F32_QNAN;
      endcase
    end else if (w_e_int >= 255) begin
      w_flags[FLAG_OF] = 1'b1;
      w_flags[FLAG_NX] = 1'b1;
      case (r_s1.rm)
        RM_RTZ:
          w_result = {r_s1.sign, F32_MAXFIN[30:0]};
        RM_RDN:
          w_result = r_s1.sign ? {1'b1, F32_INF[30:0]}
                               : F32_MAXFIN;
        RM_RUP:
          w_result = r_s1.sign ? {1'b1, F32_MAXFIN[30:0]}
                               : F32_INF;
        default:
          w_result = {r_s1.sign, F32_INF[30:0]};
      endcase
    end else if (w_e_int <= 0) begin
      // No subnormal output: tiny results collapse to signed zero.
      w_result         = {r_s1.sign, 31'd0};
      w_flags[FLAG_UF] = 1'b1;
      w_flags[FLAG_NX] = 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else if (in_flush) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s2_can_take) r_s2_v <= r_s1_v;
      if (w_ready_up)    r_s1_v <= in_valid;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_s1     <= '0;
      r_s1_e   <= '0;
      r_result <= '0;
      r_fflags <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1   <= w_s1_next;
        r_s1_e <= w_s1_e_next;
      end
      if (w_s2_load) begin
        r_result <= w_result;
        r_fflags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: rounding, overflow,
// underflow, specials, backpressure, flush and reset.
module tb_fp_mul_norm_round;

  logic              in_clk = 1'b0;
  logic              in_rst_n;
  logic              in_flush;
  logic              in_valid;
  logic              out_ready_up;
  logic [47:0]       in_product;
  logic              in_sign;
  logic signed [9:0] in_exp_sum;
  logic [1:0]        in_special;
  logic              in_invalid;
  logic [2:0]        in_rm;
  logic              out_valid;
  logic              in_ready;
  logic [31:0]       out_result;
  logic [4:0]        out_fflags;

  int n_asserts = 0;
  int n_fail    = 0;

  fp_mul_norm_round #(.EXP_W(10), .FLAGS_W(5)) dut (
    .in_clk       (in_clk),
    .in_rst_n     (in_rst_n),
    .in_flush     (in_flush),
    .in_valid     (in_valid),
    .out_ready_up (out_ready_up),
    .in_product   (in_product),
    .in_sign      (in_sign),
    .in_exp_sum   (in_exp_sum),
    .in_special   (in_special),
    .in_invalid   (in_invalid),
    .in_rm        (in_rm),
    .out_valid    (out_valid),
    .in_ready     (in_ready),
    .out_result   (out_result),
    .out_fflags   (out_fflags)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [47:0] obs,
    input logic [47:0] exp
  );
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [47:0] p,
    input logic [9:0]  e,
    input logic        sg,
    input logic [1:0]  sp,
    input logic        nv,
    input logic [2:0]  rm
  );
    in_product = p;
    in_exp_sum = e;
    in_sign    = sg;
    in_special = sp;
    in_invalid = nv;
    in_rm      = rm;
  endtask

  // Called in the window #1 after a rising edge, pipeline empty.
  task automatic run_one(
    input string       tag,
    input logic [47:0] p,
    input logic [9:0]  e,
    input logic        sg,
    input logic [1:0]  sp,
    input logic        nv,
    input logic [2:0]  rm,
    input logic [31:0] xr,
    input logic [4:0]  xf
  );
    drive(p, e, sg, sp, nv, rm);
    in_valid = 1'b1;
    in_ready = 1'b1;
    #1;
    chk({tag, ".rdy"}, 48'(out_ready_up), 48'd1);
    @(posedge in_clk); #1;
    in_valid = 1'b0;
    chk({tag, ".lat"}, 48'(out_valid), 48'd0);
    @(posedge in_clk); #1;
    chk({tag, ".vld"}, 48'(out_valid), 48'd1);
    chk({tag, ".res"}, 48'(out_result), 48'(xr));
    chk({tag, ".flg"}, 48'(out_fflags), 48'(xf));
    @(posedge in_clk); #1;
  endtask

  logic [47:0] q_p  [4];
  logic [9:0]  q_e  [4];
  logic        q_sg [4];
  logic [1:0]  q_sp [4];
  logic        q_nv [4];
  logic [31:0] q_r  [4];
  logic [4:0]  q_f  [4];

  initial begin
    int  ni;
    int  no;
    bit  stalled;
    bit  acc_in;
    bit  acc_out;

    in_rst_n = 1'b0;
    in_flush = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    drive(48'd0, 10'd0, 1'b0, 2'b00, 1'b0, 3'd0);
    #1;
    chk("rst.vld", 48'(out_valid), 48'd0);
    chk("rst.res", 48'(out_result), 48'd0);
    chk("rst.flg", 48'(out_fflags), 48'd0);
    chk("rst.rdy", 48'(out_ready_up), 48'd1);
    @(posedge in_clk); @(posedge in_clk); #1;
    in_rst_n = 1'b1;
    @(posedge in_clk); #1;

    run_one("t1", 48'h9000_0000_0000, 10'd127, 0, 2'b00, 0,
            3'd0, 32'h4010_0000, 5'h00);
    run_one("rne_tie", 48'h4000_0040_0000, 10'd127, 0, 2'b00, 0,
            3'd0, 32'h3F80_0000, 5'h01);
    run_one("rup", 48'h4000_0040_0000, 10'd127, 0, 2'b00, 0,
            3'd3, 32'h3F80_0001, 5'h01);
    run_one("rdn_neg", 48'h4000_0040_0000, 10'd127, 1, 2'b00, 0,
            3'd2, 32'hBF80_0001, 5'h01);
    run_one("rmm", 48'h4000_0040_0000, 10'd127, 0, 2'b00, 0,
            3'd4, 32'h3F80_0001, 5'h01);
    run_one("rtz_neg", 48'h4000_0040_0000, 10'd127, 1, 2'b00, 0,
            3'd1, 32'hBF80_0000, 5'h01);
    run_one("rm_rsvd", 48'h4000_0040_0000, 10'd127, 0, 2'b00, 0,
            3'd7, 32'h3F80_0000, 5'h01);
    run_one("carry", 48'h7FFF_FFC0_0000, 10'd127, 0, 2'b00, 0,
            3'd0, 32'h4000_0000, 5'h01);
    run_one("of_rne", 48'h8000_0000_0000, 10'd254, 0, 2'b00, 0,
            3'd0, 32'h7F80_0000, 5'h05);
    run_one("of_rtz", 48'h8000_0000_0000, 10'd254, 0, 2'b00, 0,
            3'd1, 32'h7F7F_FFFF, 5'h05);
    run_one("of_rdn_p", 48'h8000_0000_0000, 10'd254, 0, 2'b00, 0,
            3'd2, 32'h7F7F_FFFF, 5'h05);
    run_one("of_rdn_n", 48'h8000_0000_0000, 10'd254, 1, 2'b00, 0,
            3'd2, 32'hFF80_0000, 5'h05);
    run_one("of_rup_n", 48'h8000_0000_0000, 10'd254, 1, 2'b00, 0,
            3'd3, 32'hFF7F_FFFF, 5'h05);
    run_one("of_rup_p", 48'h8000_0000_0000, 10'd254, 0, 2'b00, 0,
            3'd3, 32'h7F80_0000, 5'h05);
    run_one("e254", 48'h4000_0000_0000, 10'd254, 0, 2'b00, 0,
            3'd0, 32'h7F00_0000, 5'h00);
    run_one("e1", 48'h4000_0000_0000, 10'd1, 0, 2'b00, 0,
            3'd0, 32'h0080_0000, 5'h00);
    run_one("uf_p", 48'h4000_0000_0000, 10'd0, 0, 2'b00, 0,
            3'd0, 32'h0000_0000, 5'h03);
    run_one("uf_n", 48'h4000_0000_0000, 10'd0, 1, 2'b00, 0,
            3'd0, 32'h8000_0000, 5'h03);
    run_one("uf_neg_e", 48'h4000_0000_0000, 10'h3FB, 0, 2'b00, 0,
            3'd0, 32'h0000_0000, 5'h03);
    run_one("nan", 48'h4000_0040_0000, 10'd127, 0, 2'b11, 1,
            3'd0, 32'h7FC0_0000, 5'h10);
    run_one("inf_n", 48'h8000_0000_0000, 10'd254, 1, 2'b10, 0,
            3'd0, 32'hFF80_0000, 5'h00);
    run_one("zero_n", 48'h4000_0040_0000, 10'd127, 1, 2'b01, 0,
            3'd0, 32'h8000_0000, 5'h00);
    run_one("prod0", 48'h0, 10'd127, 1, 2'b00, 0,
            3'd0, 32'h8000_0000, 5'h00);

    // Backpressure: four back-to-back inputs, ready low 4 cycles.
    q_p[0] = 48'h9000_0000_0000; q_e[0] = 10'd127; q_sg[0] = 0;
    q_sp[0] = 2'b00; q_nv[0] = 0;
    q_r[0] = 32'h4010_0000; q_f[0] = 5'h00;
    q_p[1] = 48'h4000_0040_0000; q_e[1] = 10'd127; q_sg[1] = 1;
    q_sp[1] = 2'b00; q_nv[1] = 0;
    q_r[1] = 32'hBF80_0000; q_f[1] = 5'h01;
    q_p[2] = 48'h4000_0000_0000; q_e[2] = 10'd0; q_sg[2] = 0;
    q_sp[2] = 2'b00; q_nv[2] = 0;
    q_r[2] = 32'h0000_0000; q_f[2] = 5'h03;
    q_p[3] = 48'h0000_0000_0000; q_e[3] = 10'd0; q_sg[3] = 0;
    q_sp[3] = 2'b11; q_nv[3] = 1;
    q_r[3] = 32'h7FC0_0000; q_f[3] = 5'h10;

    ni = 0;
    no = 0;
    stalled = 0;
    drive(q_p[0], q_e[0], q_sg[0], q_sp[0], q_nv[0], 3'd0);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && no < 4; cyc++) begin
      in_ready = (cyc >= 4);
      #1;
      if (!out_ready_up && !stalled) begin
        stalled = 1;
        chk("bp.drop_after", 48'(ni), 48'd2);
      end
      if (cyc == 3) begin
        chk("bp.hold_vld", 48'(out_valid), 48'd1);
        chk("bp.hold_res", 48'(out_result), 48'(q_r[0]));
      end
      acc_in  = in_valid && out_ready_up;
      acc_out = out_valid && in_ready;
      if (acc_out) begin
        chk("bp.res", 48'(out_result), 48'(q_r[no]));
        chk("bp.flg", 48'(out_fflags), 48'(q_f[no]));
        no++;
      end
      @(posedge in_clk); #1;
      if (acc_in) begin
        ni++;
        if (ni < 4)
          drive(q_p[ni], q_e[ni], q_sg[ni], q_sp[ni],
                q_nv[ni], 3'd0);
        else
          in_valid = 1'b0;
      end
    end
    chk("bp.stalled", 48'(stalled), 48'd1);
    chk("bp.count", 48'(no), 48'd4);
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge in_clk); #1;

    // Flush with valid: input dropped, ready unaffected.
    drive(48'h9000_0000_0000, 10'd127, 0, 2'b00, 0, 3'd0);
    in_valid = 1'b1;
    in_flush = 1'b1;
    #1;
    chk("fl.rdy", 48'(out_ready_up), 48'd1);
    @(posedge in_clk); #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    chk("fl.s1", 48'(out_valid), 48'd0);
    @(posedge in_clk); #1;
    chk("fl.s2", 48'(out_valid), 48'd0);

    // Flush discards a stalled output.
    in_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge in_clk); #1;
    in_valid = 1'b0;
    @(posedge in_clk); #1;
    chk("fl2.pend", 48'(out_valid), 48'd1);
    in_flush = 1'b1;
    @(posedge in_clk); #1;
    in_flush = 1'b0;
    chk("fl2.gone", 48'(out_valid), 48'd0);
    in_ready = 1'b1;
    @(posedge in_clk); #1;
    chk("fl2.after", 48'(out_valid), 48'd0);

    // Reset mid-stream.
    in_valid = 1'b1;
    @(posedge in_clk); #1;
    @(posedge in_clk); #1;
    chk("rs.pre", 48'(out_valid), 48'd1);
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rs.vld", 48'(out_valid), 48'd0);
    chk("rs.res", 48'(out_result), 48'd0);
    @(posedge in_clk); #1;
    in_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge in_clk); #1;
      chk("rs.stale", 48'(out_valid), 48'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
